// File: rtl/sumador4bits.sv
// sumador4bits: registered unsigned 4-bit ripple-carry adder with a 5-bit result.
// A valid bit travels alongside the data and qualifies each registered sum.
// Optional macro SUMADOR4BITS_IN_REG_EN adds an input register stage
// (latency 2 instead of 1); results and reset values are otherwise identical.
module sumador4bits (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       in_valid,
  output logic [4:0] sum,
  output logic       out_valid
);

  localparam int unsigned W = 4;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_valid;

`ifdef SUMADOR4BITS_IN_REG_EN
  // Input stage: capture operands and valid, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= W'(0);
      op_b     <= W'(0);
      op_valid <= 1'b0;
    end else begin
      op_a     <= a;
      op_b     <= b;
      op_valid <= in_valid;
    end
  end
`else
  assign op_a     = a;
  assign op_b     = b;
  assign op_valid = in_valid;
`endif

  // Ripple chain of full-adder cells, bit 0 to bit W-1, carry-in tied low
  logic [W:0]   carry;
  logic [W-1:0] bit_sum;
  logic [W:0]   add_result_c;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign bit_sum[i]  = op_a[i] ^ op_b[i] ^ carry[i];
    assign carry[i+1]  = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
  end

  assign add_result_c = {carry[W], bit_sum};

  // Output register: sum updates every cycle, out_valid qualifies it
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= (W+1)'(0);
      out_valid <= 1'b0;
    end else begin
      sum       <= add_result_c;
      out_valid <= op_valid;
    end
  end

endmodule

// File: tb/tb_sumador4bits.sv
// tb_sumador4bits: directed, scoreboard-based bench for sumador4bits.
// Works for both builds; latency follows SUMADOR4BITS_IN_REG_EN.
module tb_sumador4bits;

`ifdef SUMADOR4BITS_IN_REG_EN
  localparam int unsigned LAT = 2;
`else
  localparam int unsigned LAT = 1;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       in_valid;
  logic [4:0] sum;
  logic       out_valid;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] sum;
  } exp_t;

  exp_t exp_q[$];

  sumador4bits dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .sum       (sum),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus: drive at negedge, push expectation, check after posedge
  task automatic step(input logic r, input logic [3:0] av, input logic [3:0] bv,
                      input logic v, input string tag);
    exp_t e;
    exp_t got;
    @(negedge clk);
    rst      = r;
    a        = av;
    b        = bv;
    in_valid = v;
    if (r) begin
      for (int i = 0; i < exp_q.size(); i++) exp_q[i] = '0;
      e = '0;
    end else begin
      e.valid = v;
      e.sum   = 5'({1'b0, av} + {1'b0, bv});
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (r) begin
      total++;
      assert (sum === 5'd0 && out_valid === 1'b0)
      else begin
        bad++;
        $error("FAIL %s reset_out: sum=%0d out_valid=%b required sum=0 out_valid=0",
               tag, sum, out_valid);
      end
    end
    if (exp_q.size() == LAT) begin
      got = exp_q.pop_front();
      total++;
      assert (out_valid === got.valid)
      else begin
        bad++;
        $error("FAIL %s out_valid: got=%b required=%b", tag, out_valid, got.valid);
      end
      total++;
      assert (sum === got.sum)
      else begin
        bad++;
        $error("FAIL %s sum: got=%0d required=%0d", tag, sum, got.sum);
      end
    end
  endtask

  initial begin
    rst = 1'b1; a = 4'h0; b = 4'h0; in_valid = 1'b0;

    // Reset held 3 cycles with live-looking operands
    for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 4'hF, 1'b1, "reset_hold");

    // First valid after reset release, then directed boundary cases
    step(1'b0, 4'b0010, 4'b0011, 1'b1, "small");
    step(1'b0, 4'b1100, 4'b1010, 1'b1, "carry_out");
    step(1'b0, 4'd0,    4'd0,    1'b1, "zero");
    step(1'b0, 4'd15,   4'd15,   1'b1, "max");
    step(1'b0, 4'd15,   4'd1,    1'b1, "carry_only");
    step(1'b0, 4'd7,    4'd8,    1'b0, "idle_a");
    step(1'b0, 4'd9,    4'd9,    1'b0, "idle_b");
    step(1'b0, 4'd1,    4'd2,    1'b1, "after_idle");

    // Exhaustive back-to-back sweep
    for (int i = 0; i < 256; i++)
      step(1'b0, 4'(i >> 4), 4'(i), 1'b1, "sweep");

    // Mid-stream reset, then resume
    for (int i = 0; i < 4; i++) step(1'b0, 4'(i + 10), 4'(i + 3), 1'b1, "pre_rst");
    step(1'b1, 4'd14, 4'd13, 1'b1, "mid_rst");
    for (int i = 0; i < 4; i++) step(1'b0, 4'(i + 5), 4'(15 - i), 1'b1, "post_rst");

    // Drain pipeline
    for (int i = 0; i < int'(LAT); i++) step(1'b0, 4'd0, 4'd0, 1'b0, "drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
